// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit pair: state encoding,
// status bit positions, oversampling ratio and I/O port addresses.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [7:0] ADDR_DATA = 8'hE8;
    localparam logic [7:0] ADDR_CTRL = 8'hE9;

    localparam int STAT_RDY  = 0;
    localparam int STAT_OVR  = 1;
    localparam int STAT_FERR = 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        START     = S_START,
        DATA      = S_DATA,
        STOP      = S_STOP,
        WAIT_HIGH = S_WAIT_HIGH
    } rx_state_e;

    // Rounded clocks-per-oversample-tick divider.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer; head reads 0xFF while empty.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o = empty_o ? '1 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, sticky error flags and a small FWFT buffer.
// dbg_state exposes the receive FSM state for observation.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_pop,
    input  logic       stat_rd,
    output logic [7:0] dout,
    output logic [7:0] status,
    output logic       rdy,
    output logic       ovr,
    output logic       ferr,
    output logic [2:0] dbg_state
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int DW  = $clog2(DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    rx_state_e     state_q, state_d;
    logic          rx_meta_q, rx_sync_q;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
    logic          tick;
    logic          push;
    logic          ferr_set;
    logic          ovr_set;
    logic          pop_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            div_q     <= '0;
            tcnt_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Divider is parked at zero in IDLE so tick phase is locked to the start edge.
    assign tick = (state_q != IDLE) && (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        tcnt_d    = tcnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (!rx_sync_q) state_d = START;
            end
            START: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == 4'd7) begin
                        tcnt_d = '0;
                        if (rx_sync_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == 4'd15) begin
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == 4'd15) begin
                        if (rx_sync_q) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = WAIT_HIGH;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_ok  = rd_pop && (fifo_count != '0);
    assign ovr_set = push && fifo_full && !pop_ok;

    // A set event in the same cycle as a status read wins.
    always_comb begin
        ovr_d  = ovr_set  || (ovr_q  && !stat_rd);
        ferr_d = ferr_set || (ferr_q && !stat_rd);
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (rst),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rd_pop),
        .head_o  (dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rdy       = !fifo_empty;
    assign ovr       = ovr_q;
    assign ferr      = ferr_q;
    assign dbg_state = state_q;

    always_comb begin
        status            = 8'h00;
        status[STAT_RDY]  = rdy;
        status[STAT_OVR]  = ovr_q;
        status[STAT_FERR] = ferr_q;
    end

endmodule
